regfile_mp_swc: RTL and testbench
=================================

// Module: regfile_mp_swc
// PURPOSE
//   Parametrised multi-read-port register file for the RV32I core; successor to the 2-read/1-write regfile.
//   Adds: configurable width/depth/read-port count, write-to-read bypass on every port,
//   a per-register busy scoreboard for the issue stage, and a sequenced clear engine.
//   Sits between decode/issue (reads, reservations) and writeback (writes).
// PARAMETERS
//   XLEN      32   data width of each register
//   NREG      32   number of registers (power of 2, >=4); AW = $clog2(NREG)
//   NRD       2    number of read ports (1..4)
//   ZERO_REG  1    1: register 0 reads 0 and ignores writes and reservations; 0: ordinary register
// PORTS
//   hclk         in   1          clock, all state on rising edge
//   hrstn        in   1          asynchronous active-low reset
//   reg_wen      in   1          write enable
//   reg_waddr    in   AW         write address
//   reg_wdata    in   XLEN       write data
//   reg_wpar_inv in   1          invert stored parity on this write (fault injection; ignored w/o macro)
//   reg_ren      in   NRD        per-port read enable
//   reg_raddr    in   NRD*AW     read addresses, port k at [k*AW +: AW]
//   reg_rdata    out  NRD*XLEN   registered read data, port k at [k*XLEN +: XLEN]
//   reg_rbusy    out  NRD        registered busy flag of the register read on port k
//   reg_perr     out  NRD        registered parity error on port k (0 w/o macro)
//   rsv_en       in   1          reserve: mark rsv_addr busy (pending write)
//   rsv_addr     in   AW         register to reserve
//   clr_req      in   1          start clear sequence (pulse)
//   clr_busy     out  1          high while clear engine runs
//   clr_done     out  1          one-cycle pulse when clear completes
// BEHAVIOUR
//   Reset (hrstn=0, async): all registers, busy bits, reg_rdata, reg_rbusy, reg_perr, clr_busy, clr_done = 0; FSM -> IDLE.
//   Write: when reg_wen and FSM IDLE, regfile[reg_waddr] <= reg_wdata on the edge; addr 0 dropped if ZERO_REG.
//   Read: 1-cycle latency. Port k with reg_ren[k]=1 at edge N presents data after edge N.
//     Bypass: if reg_wen and reg_waddr==raddr_k (and not reg0 with ZERO_REG), rdata_k <= reg_wdata.
//     Otherwise rdata_k <= regfile[raddr_k]. reg_ren[k]=0 -> rdata_k, rbusy_k, perr_k <= 0.
//     All ports independent; any ports may read the same address in the same cycle.
//   Scoreboard: busy[NREG] bits.
//     rsv_en sets busy[rsv_addr]; reg_wen clears busy[reg_waddr].
//     Same address in the same cycle: reserve wins (busy stays 1).
//     rbusy_k <= busy[raddr_k] & ~(reg_wen & reg_waddr==raddr_k) | (rsv_en & rsv_addr==raddr_k).
//     Reg0 never busy if ZERO_REG.
//   Clear FSM: IDLE --clr_req--> CLEAR; cnt runs 0..NREG-1, one register zeroed per cycle (NREG cycles).
//     cnt==NREG-1 -> DONE (1 cycle, clr_done=1) -> IDLE. clr_busy=1 in CLEAR and DONE.
//     Entering CLEAR zeroes all busy bits at once.
//     In CLEAR/DONE: writes, reservations and further clr_req are dropped; reads return 0 with rbusy=0.
//     Reset mid-clear aborts to IDLE with everything zero.
//   Width: counters AW+1 bits, no wrap; no arithmetic on data.
// CONFIGURATION
//   REGFILE_PARITY_EN defined:
//     each entry stores an extra even-parity bit = ^wdata ^ reg_wpar_inv.
//     perr_k <= 1 with rdata_k when stored parity != ^stored data.
//     Bypassed reads and reg0 never flag. Clear writes correct parity.
//   Not defined: no parity storage; reg_perr tied 0; reg_wpar_inv unused.
// TESTING
//   1. Reset, write x5=0xDEADBEEF, next cycle read x5 on port0 -> rdata0=0xDEADBEEF one cycle later, rbusy0=0.
//   2. Same cycle: write x7=0x12345678, ren all ports raddr=7 -> every port returns 0x12345678 (bypass).
//   3. Write x0=0xFFFFFFFF (ZERO_REG=1), read x0 -> 0; rsv x0 -> rbusy=0.
//   4. rsv x3, read x3 -> rbusy=1; write x3 with rsv x3 same cycle -> still busy; write x3 alone -> rbusy=0.
//   5. Fill x1..x31 = index; clr_req -> clr_busy for NREG+1 cycles, clr_done pulse, writes inside dropped, all reads 0 after.
//   6. (PARITY_EN) write x9=0x1 with reg_wpar_inv=1, read x9 -> rdata=0x1, perr=1; rewrite without inv -> perr=0.

Source files
------------

// File: rtl/regfile_mp_swc.sv
// Multi-read-port register file with write-to-read bypass, busy scoreboard and sequenced clear.
// Optional per-entry even parity with fault injection: define REGFILE_PARITY_EN.

module regfile_mp_swc_rport #(
  parameter int XLEN = 32
) (
  input  logic            hclk,
  input  logic            hrstn,
  input  logic            ren,
  input  logic            kill,
  input  logic            byp,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] mdata,
  input  logic            busy_nxt,
  input  logic            perr_nxt,
  output logic [XLEN-1:0] rdata,
  output logic            rbusy,
  output logic            perr
);
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      rdata <= '0;
      rbusy <= 1'b0;
      perr  <= 1'b0;
    end else if (!ren || kill) begin
      rdata <= '0;
      rbusy <= 1'b0;
      perr  <= 1'b0;
    end else begin
      rdata <= byp ? wdata : mdata;
      rbusy <= busy_nxt;
      // forwarded data never went through storage, so it cannot carry a parity fault
      perr  <= perr_nxt & ~byp;
    end
  end
endmodule

module regfile_mp_swc #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                hclk,
  input  logic                hrstn,
  input  logic                reg_wen,
  input  logic [AW-1:0]       reg_waddr,
  input  logic [XLEN-1:0]     reg_wdata,
  input  logic                reg_wpar_inv,
  input  logic [NRD-1:0]      reg_ren,
  input  logic [NRD*AW-1:0]   reg_raddr,
  output logic [NRD*XLEN-1:0] reg_rdata,
  output logic [NRD-1:0]      reg_rbusy,
  output logic [NRD-1:0]      reg_perr,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                clr_done
);
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;
  localparam logic [AW:0] CNT_LAST = (AW+1)'(NREG-1);
  localparam bit          ZR       = (ZERO_REG != 0);

  state_t                    state;
  logic [AW:0]               cnt;
  logic [NREG-1:0][XLEN-1:0] mem;
  logic [NREG-1:0]           busy;
  logic                      idle, wen_eff, rsv_eff;

  assign idle    = (state == S_IDLE);
  assign wen_eff = reg_wen & idle & ~(ZR & (reg_waddr == '0));
  assign rsv_eff = rsv_en  & idle & ~(ZR & (rsv_addr  == '0));

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
      mem      <= '0;
      busy     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (wen_eff) begin
            mem[reg_waddr]  <= reg_wdata;
            busy[reg_waddr] <= 1'b0;
          end
          // reserve is applied after the write-clear so it wins on a same-address collision
          if (rsv_eff) busy[rsv_addr] <= 1'b1;
          if (clr_req) begin
            state    <= S_CLEAR;
            cnt      <= '0;
            clr_busy <= 1'b1;
            busy     <= '0;
          end
        end
        S_CLEAR: begin
          mem[cnt[AW-1:0]] <= '0;
          cnt              <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state    <= S_DONE;
            clr_done <= 1'b1;
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          clr_done <= 1'b0;
          clr_busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef REGFILE_PARITY_EN
  logic [NREG-1:0] par;

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn)               par <= '0;
    else if (wen_eff)         par[reg_waddr] <= (^reg_wdata) ^ reg_wpar_inv;
    else if (state == S_CLEAR) par[cnt[AW-1:0]] <= 1'b0;
  end
`else
  logic unused_wpar;
  assign unused_wpar = reg_wpar_inv;
`endif

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic          zero_a, hit, pe;

    assign a      = reg_raddr[k*AW +: AW];
    assign zero_a = ZR & (a == '0);
    assign hit    = wen_eff & (reg_waddr == a);
`ifdef REGFILE_PARITY_EN
    assign pe     = ~zero_a & (par[a] ^ (^mem[a]));
`else
    assign pe     = 1'b0;
`endif

    regfile_mp_swc_rport #(.XLEN(XLEN)) u_rport (
      .hclk     (hclk),
      .hrstn    (hrstn),
      .ren      (reg_ren[k]),
      .kill     (~idle),
      .byp      (hit),
      .wdata    (reg_wdata),
      .mdata    (zero_a ? '0 : mem[a]),
      .busy_nxt ((busy[a] & ~hit) | (rsv_eff & (rsv_addr == a))),
      .perr_nxt (pe),
      .rdata    (reg_rdata[k*XLEN +: XLEN]),
      .rbusy    (reg_rbusy[k]),
      .perr     (reg_perr[k])
    );
  end
endmodule

// File: tb/tb_regfile_mp_swc.sv
// Randomized and directed bench for regfile_mp_swc against an array-level reference model.
module tb_regfile_mp_swc;
  localparam int XLEN = 32, NREG = 32, NRD = 3, AW = 5;
`ifdef REGFILE_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic                hclk = 1'b0, hrstn = 1'b0;
  logic                reg_wen, reg_wpar_inv, rsv_en, clr_req;
  logic [AW-1:0]       reg_waddr, rsv_addr;
  logic [XLEN-1:0]     reg_wdata;
  logic [NRD-1:0]      reg_ren, reg_rbusy, reg_perr;
  logic [NRD*AW-1:0]   reg_raddr;
  logic [NRD*XLEN-1:0] reg_rdata;
  logic                clr_busy, clr_done;

  always #5 hclk = ~hclk;

  regfile_mp_swc #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_REG(1)) dut (
    .hclk(hclk), .hrstn(hrstn), .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .reg_wpar_inv(reg_wpar_inv), .reg_ren(reg_ren), .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
    .reg_rbusy(reg_rbusy), .reg_perr(reg_perr), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done));

  int checks = 0, fails = 0;

  // reference model: register contents, pending-write flags, corrupted-parity flags, clear window
  logic [XLEN-1:0] m_reg [NREG];
  bit              m_busy [NREG];
  bit              m_bad  [NREG];
  int              m_clr_rem;
  logic [XLEN-1:0] e_rd [NRD];
  bit              e_rb [NRD];
  bit              e_pe [NRD];
  bit              e_cb, e_cd;

  function automatic logic [XLEN-1:0] rd(int k);
    return reg_rdata[k*XLEN +: XLEN];
  endfunction

  task automatic idle_in();
    reg_wen = 0; reg_waddr = '0; reg_wdata = '0; reg_wpar_inv = 0;
    reg_ren = '0; reg_raddr = '0; rsv_en = 0; rsv_addr = '0; clr_req = 0;
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < NREG; i++) begin m_reg[i] = '0; m_busy[i] = 0; m_bad[i] = 0; end
    m_clr_rem = 0;
  endtask

  task automatic set_rd(int k, int a);
    reg_ren[k] = 1'b1;
    reg_raddr[k*AW +: AW] = AW'(a);
  endtask

  // predicts outputs of the coming edge from current inputs, advances the model, then clocks
  task automatic step();
    bit act, weff, reff, byp;
    logic [AW-1:0] a;
    act  = (m_clr_rem == 0);
    weff = act && reg_wen && (reg_waddr != 0);
    reff = act && rsv_en && (rsv_addr != 0);
    for (int k = 0; k < NRD; k++) begin
      a = reg_raddr[k*AW +: AW];
      if (!reg_ren[k] || !act) begin
        e_rd[k] = '0; e_rb[k] = 0; e_pe[k] = 0;
      end else begin
        byp     = weff && (reg_waddr == a);
        e_rd[k] = byp ? reg_wdata : m_reg[a];
        e_rb[k] = (m_busy[a] && !byp) || (reff && rsv_addr == a);
        e_pe[k] = PAR && !byp && (a != 0) && m_bad[a];
      end
    end
    if (act) begin
      if (weff) begin m_reg[reg_waddr] = reg_wdata; m_busy[reg_waddr] = 0; m_bad[reg_waddr] = reg_wpar_inv; end
      if (reff) m_busy[rsv_addr] = 1;
      if (clr_req) begin
        for (int i = 0; i < NREG; i++) begin m_reg[i] = '0; m_busy[i] = 0; m_bad[i] = 0; end
        m_clr_rem = NREG + 1;
      end
    end else m_clr_rem--;
    e_cb = (m_clr_rem > 0);
    e_cd = (m_clr_rem == 1);
    @(posedge hclk); #1;
  endtask

  task automatic test_reset();
    idle_in(); mdl_reset();
    reg_ren = '1; rsv_en = 1; rsv_addr = 5'd3;
    #23;
    checks++;
    if (reg_rdata !== '0 || reg_rbusy !== '0 || reg_perr !== '0 || clr_busy !== 0 || clr_done !== 0) begin
      fails++; $display("FAIL reset: got rdata=%h rbusy=%b perr=%b clr_busy=%b clr_done=%b want all zero",
                        reg_rdata, reg_rbusy, reg_perr, clr_busy, clr_done);
    end
    hrstn = 1; idle_in(); step();
  endtask

  task automatic test_write_read();
    idle_in(); reg_wen = 1; reg_waddr = 5'd5; reg_wdata = 32'hDEADBEEF; step();
    idle_in(); set_rd(0, 5); step();
    checks++;
    if (rd(0) !== 32'hDEADBEEF || reg_rbusy[0] !== 0 || rd(1) !== '0) begin
      fails++; $display("FAIL write_read: got p0=%h busy=%b p1=%h want p0=deadbeef busy=0 p1=0", rd(0), reg_rbusy[0], rd(1));
    end
  endtask

  task automatic test_bypass();
    idle_in(); reg_wen = 1; reg_waddr = 5'd7; reg_wdata = 32'h12345678;
    for (int k = 0; k < NRD; k++) set_rd(k, 7);
    step();
    for (int k = 0; k < NRD; k++) begin
      checks++;
      if (rd(k) !== 32'h12345678 || reg_rbusy[k] !== 0) begin
        fails++; $display("FAIL bypass p%0d: got %h busy=%b want 12345678 busy=0", k, rd(k), reg_rbusy[k]);
      end
    end
  endtask

  task automatic test_zero_reg();
    idle_in(); reg_wen = 1; reg_waddr = 5'd0; reg_wdata = 32'hFFFFFFFF; set_rd(0, 0); step();
    checks++;
    if (rd(0) !== '0) begin fails++; $display("FAIL zero_bypass: got %h want 0", rd(0)); end
    idle_in(); rsv_en = 1; rsv_addr = 5'd0; set_rd(0, 0); set_rd(1, 0); step();
    checks++;
    if (rd(0) !== '0 || reg_rbusy[1:0] !== 2'b00) begin
      fails++; $display("FAIL zero_rsv: got data=%h rbusy=%b want 0 00", rd(0), reg_rbusy[1:0]);
    end
    idle_in(); set_rd(2, 0); step();
    checks++;
    if (rd(2) !== '0 || reg_rbusy[2] !== 0) begin
      fails++; $display("FAIL zero_read: got data=%h busy=%b want 0 0", rd(2), reg_rbusy[2]);
    end
  endtask

  task automatic test_scoreboard();
    idle_in(); rsv_en = 1; rsv_addr = 5'd3; set_rd(1, 3); step();
    checks++;
    if (reg_rbusy[1] !== 1) begin fails++; $display("FAIL sb_rsv_same_cycle: got %b want 1", reg_rbusy[1]); end
    idle_in(); set_rd(0, 3); step();
    checks++;
    if (reg_rbusy[0] !== 1) begin fails++; $display("FAIL sb_rsv: got %b want 1", reg_rbusy[0]); end
    idle_in(); reg_wen = 1; reg_waddr = 5'd3; reg_wdata = 32'hA5; rsv_en = 1; rsv_addr = 5'd3; step();
    idle_in(); set_rd(0, 3); step();
    checks++;
    if (reg_rbusy[0] !== 1 || rd(0) !== 32'hA5) begin
      fails++; $display("FAIL sb_rsv_wins: got busy=%b data=%h want 1 a5", reg_rbusy[0], rd(0));
    end
    idle_in(); reg_wen = 1; reg_waddr = 5'd3; reg_wdata = 32'h5A; set_rd(2, 3); step();
    checks++;
    if (reg_rbusy[2] !== 0 || rd(2) !== 32'h5A) begin
      fails++; $display("FAIL sb_write_same_cycle: got busy=%b data=%h want 0 5a", reg_rbusy[2], rd(2));
    end
    idle_in(); set_rd(0, 3); step();
    checks++;
    if (reg_rbusy[0] !== 0) begin fails++; $display("FAIL sb_write_clears: got %b want 0", reg_rbusy[0]); end
  endtask

`ifdef REGFILE_PARITY_EN
  task automatic test_parity();
    idle_in(); reg_wen = 1; reg_waddr = 5'd9; reg_wdata = 32'h1; reg_wpar_inv = 1; set_rd(1, 9); step();
    checks++;
    if (reg_perr[1] !== 0) begin fails++; $display("FAIL par_bypass: got %b want 0", reg_perr[1]); end
    idle_in(); set_rd(0, 9); step();
    checks++;
    if (rd(0) !== 32'h1 || reg_perr[0] !== 1) begin
      fails++; $display("FAIL par_inject: got data=%h perr=%b want 1 1", rd(0), reg_perr[0]);
    end
    idle_in(); reg_wen = 1; reg_waddr = 5'd9; reg_wdata = 32'h1; step();
    idle_in(); set_rd(0, 9); step();
    checks++;
    if (reg_perr[0] !== 0) begin fails++; $display("FAIL par_rewrite: got %b want 0", reg_perr[0]); end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      idle_in();
      reg_wen = 1'($urandom); reg_waddr = AW'($urandom_range(0, 7)); reg_wdata = $urandom();
      reg_wpar_inv = ($urandom_range(0, 3) == 0);
      rsv_en = 1'($urandom); rsv_addr = AW'($urandom_range(0, 7));
      reg_ren = NRD'($urandom);
      for (int k = 0; k < NRD; k++) reg_raddr[k*AW +: AW] = AW'($urandom_range(0, 7));
      step();
      for (int k = 0; k < NRD; k++) begin
        checks++;
        if (rd(k) !== e_rd[k] || reg_rbusy[k] !== e_rb[k] || reg_perr[k] !== e_pe[k]) begin
          fails++; $display("FAIL rand c%0d p%0d: got data=%h busy=%b perr=%b want data=%h busy=%b perr=%b",
                            c, k, rd(k), reg_rbusy[k], reg_perr[k], e_rd[k], e_rb[k], e_pe[k]);
        end
      end
    end
  endtask

  task automatic test_clear();
    int nbusy, ndone;
    for (int i = 1; i < NREG; i++) begin
      idle_in(); reg_wen = 1; reg_waddr = AW'(i); reg_wdata = XLEN'(i); step();
    end
    idle_in(); rsv_en = 1; rsv_addr = 5'd4; step();
    idle_in(); clr_req = 1; step();
    nbusy = clr_busy ? 1 : 0; ndone = clr_done ? 1 : 0;
    for (int c = 0; c < NREG + 3; c++) begin
      idle_in();
      if (m_clr_rem > 0) begin
        reg_wen = 1; reg_waddr = AW'($urandom_range(1, NREG-1)); reg_wdata = $urandom();
        rsv_en = 1; rsv_addr = AW'($urandom_range(1, NREG-1)); clr_req = 1'($urandom);
        reg_ren = '1;
        for (int k = 0; k < NRD; k++) reg_raddr[k*AW +: AW] = reg_waddr;
      end
      step();
      if (clr_busy === 1'b1) nbusy++;
      if (clr_done === 1'b1) ndone++;
      checks++;
      if (clr_busy !== e_cb || clr_done !== e_cd || rd(0) !== e_rd[0] || reg_rbusy[0] !== e_rb[0]) begin
        fails++; $display("FAIL clr_seq c%0d: got busy=%b done=%b rd=%h rb=%b want busy=%b done=%b rd=%h rb=%b",
                          c, clr_busy, clr_done, rd(0), reg_rbusy[0], e_cb, e_cd, e_rd[0], e_rb[0]);
      end
    end
    checks++;
    if (nbusy != NREG + 1 || ndone != 1) begin
      fails++; $display("FAIL clr_len: got busy_cycles=%0d done_pulses=%0d want %0d 1", nbusy, ndone, NREG + 1);
    end
    for (int a = 0; a < NREG; a += NRD) begin
      idle_in();
      for (int k = 0; k < NRD; k++) if (a + k < NREG) set_rd(k, a + k);
      step();
      for (int k = 0; k < NRD; k++) if (a + k < NREG) begin
        checks++;
        if (rd(k) !== '0 || reg_rbusy[k] !== 0) begin
          fails++; $display("FAIL clr_after x%0d: got data=%h busy=%b want 0 0", a + k, rd(k), reg_rbusy[k]);
        end
      end
    end
  endtask

  task automatic test_reset_midclear();
    idle_in(); reg_wen = 1; reg_waddr = 5'd5; reg_wdata = 32'hCAFE; step();
    idle_in(); clr_req = 1; step();
    idle_in(); repeat (4) step();
    hrstn = 0; #2;
    checks++;
    if (clr_busy !== 0 || clr_done !== 0 || reg_rdata !== '0) begin
      fails++; $display("FAIL rst_mid_clr: got busy=%b done=%b rdata=%h want 0 0 0", clr_busy, clr_done, reg_rdata);
    end
    hrstn = 1; mdl_reset(); step();
    idle_in(); set_rd(0, 5); reg_wen = 1; reg_waddr = 5'd6; reg_wdata = 32'h66; step();
    checks++;
    if (rd(0) !== '0 || clr_busy !== 0) begin
      fails++; $display("FAIL rst_mid_clr_after: got x5=%h busy=%b want 0 0", rd(0), clr_busy);
    end
    idle_in(); set_rd(1, 6); step();
    checks++;
    if (rd(1) !== 32'h66) begin fails++; $display("FAIL rst_mid_clr_idle: got x6=%h want 66", rd(1)); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
`ifdef REGFILE_PARITY_EN
    test_parity();
`endif
    test_random();
    test_clear();
    test_reset_midclear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
